pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use stalls, branch/jump flushes, whole-pipeline freezes for slow memory, and interrupt entry. It drives the write-enable, flush and bubble controls of the stage registers and the PC.
- Control outputs are combinational from the current inputs and the registered state.
- The interrupt FSM and the performance counters are registered.

Parameters:
CNT_W, 16, width of the saturating performance counters
IRQ_MAX_WAIT, 8, cycles the IRQ FSM stays in PEND before an entry is forced

Ports:
sysclk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_rs  in  5  Rs field of the instruction in ID
id_rt  in  5  Rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads Rs
id_uses_rt  in  1  ID instruction reads Rt
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  destination register of the load in EX
id_jump  in  1  ID holds j/jal/jr/jalr (target resolved in ID)
ex_branch_taken  in  1  branch in EX resolved taken
mem_wait  in  1  data memory/peripheral not ready; freeze the pipeline
irq_req  in  1  level interrupt request
id_eret  in  1  ID holds the interrupt-return instruction
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_flush  out  1  zero the IF/ID instruction on the next edge
id_ex_bubble  out  1  zero the ID/EX control fields on the next edge
pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB (freeze)
irq_take  out  1  one-cycle pulse: PC selects the exception vector, the IRQ bit enters the pipeline
irq_state  out  2  FSM state (IDLE=0, PEND=1, TAKE=2, MASKED=3)
stall_cnt  out  CNT_W  load-use plus freeze cycles, saturating
flush_cnt  out  CNT_W  cycles with if_flush=1, saturating

Behaviour:
- Reset: reset is synchronous, active-high. While reset=1, all 1-bit outputs are 0. After the reset edge: irq_state=IDLE, stall_cnt=0, flush_cnt=0, pend timer=0. Reset asserted mid-stall or mid-IRQ aborts immediately; no pending state survives.
- Hazard detection, same cycle, zero latency:
  - load_use = ex_memread & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
  - Register 0 never causes a stall.
- Priority, highest first; exactly one case applies per cycle:
  1. mem_wait: pipe_hold=1, pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=0, irq_take=0.
  2. ex_branch_taken: pc_write=1, if_id_write=1, if_flush=1, id_ex_bubble=1. Branch beats load-use, because the stalled instruction is on the wrong path.
  3. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0.
  4. irq_state==TAKE: pc_write=1, if_id_write=1, if_flush=1, irq_take=1.
  5. id_jump: pc_write=1, if_id_write=1, if_flush=1.
  6. default: pc_write=1, if_id_write=1; all other outputs 0.
- pipe_hold=0 in every case except case 1.
- IRQ FSM, advances only when mem_wait=0; fully frozen while mem_wait=1:
  - IDLE: irq_req -> PEND; timer cleared.
  - PEND: -> TAKE at the first cycle with no branch_taken, no load_use and no id_jump ("clean"). Timer increments each non-clean cycle.
  - PEND: when the timer reaches IRQ_MAX_WAIT and the cycle has no branch_taken, -> TAKE even under load_use or id_jump. In that cycle the TAKE transition wins over the stall.
  - PEND: irq_req dropping while in PEND -> IDLE.
  - TAKE: lasts exactly one cycle -> MASKED.
  - MASKED: irq_req is ignored. id_eret=1 with mem_wait=0 -> IDLE.
  - id_eret in any state other than MASKED is ignored.
- Counters:
  - stall_cnt increments when (mem_wait | (load_use & ~ex_branch_taken)).
  - flush_cnt increments when if_flush=1.
  - Both saturate at all-ones and never wrap.
- Invariants, all asserted by the bench:
  - if_flush & ~if_id_write is never true.
  - irq_take implies irq_state==TAKE.
  - pipe_hold implies ~pc_write.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - IRQ state encodings (IDLE/PEND/TAKE/MASKED as 2-bit constants);
  - register-index width 5;
  - the zero-register constant.
- One sub-module is natural: sat_counter (parameter W; inputs sysclk, reset, inc; output count). It is instantiated twice, for stall_cnt and flush_cnt.
- Hazard comparators and the IRQ FSM stay in the top module.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0->1. Repeat with ex_rt=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 and load_use=1 -> if_flush=1, id_ex_bubble=1, pc_write=1; stall_cnt unchanged; flush_cnt +1.
- Freeze: mem_wait=1 for 3 cycles with irq_req=1 -> pipe_hold=1, pc_write=0 throughout, irq_state stays IDLE, stall_cnt +3. FSM reaches PEND 1 cycle after mem_wait drops.
- IRQ entry: irq_req=1 on a clean pipeline -> PEND next cycle, TAKE the cycle after with irq_take=1 and if_flush=1, then MASKED. Further irq_req is ignored. id_eret=1 -> IDLE.
- IRQ starvation: irq_req=1 with id_jump=1 held continuously -> TAKE forced after 8 PEND cycles.
- Saturation and reset: CNT_W=4, 20 consecutive load-use cycles -> stall_cnt=15 and holds. Then reset=1 in MASKED state -> next cycle irq_state=0, counters 0, all 1-bit outputs 0 while reset is held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_PEND   = 2'd1,
        IRQ_TAKE   = 2'd2,
        IRQ_MASKED = 2'd3
    } irq_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stage-register sequencer: load-use stalls, branch/jump flushes,
// memory freezes and interrupt entry, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned IRQ_MAX_WAIT = 8
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 id_jump,
    input  logic                 ex_branch_taken,
    input  logic                 mem_wait,
    input  logic                 irq_req,
    input  logic                 id_eret,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_flush,
    output logic                 id_ex_bubble,
    output logic                 pipe_hold,
    output logic                 irq_take,
    output logic [1:0]           irq_state,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // Timer counts non-clean PEND cycles; entry is forced on the last allowed one.
    localparam int unsigned TMR_W = (IRQ_MAX_WAIT < 2) ? 1 : $clog2(IRQ_MAX_WAIT);
    localparam logic [TMR_W-1:0] TMR_DUE = TMR_W'(IRQ_MAX_WAIT - 1);

    irq_state_e       r_irq_state;
    logic [TMR_W-1:0] r_timer;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_clean;
    logic w_due;
    logic w_stall_inc;

    assign w_rs_hit    = id_uses_rs && (id_rs == ex_rt);
    assign w_rt_hit    = id_uses_rt && (id_rt == ex_rt);
    assign w_load_use  = ex_memread && (ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);
    assign w_clean     = !ex_branch_taken && !w_load_use && !id_jump;
    assign w_due       = (r_timer >= TMR_DUE) && !ex_branch_taken;
    assign w_stall_inc = mem_wait || (w_load_use && !ex_branch_taken);

    // Stage-register controls, highest-priority condition first.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        irq_take     = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                pipe_hold = 1'b1;
            end else if (ex_branch_taken) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                id_ex_bubble = 1'b1;
            end else if (r_irq_state == IRQ_TAKE) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_flush    = 1'b1;
                irq_take    = 1'b1;
            end else if (id_jump) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_flush    = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    // Interrupt entry FSM; frozen along with the pipeline during mem_wait.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_irq_state <= IRQ_IDLE;
            r_timer     <= '0;
        end else if (!mem_wait) begin
            case (r_irq_state)
                IRQ_IDLE: begin
                    r_timer <= '0;
                    if (irq_req) begin
                        r_irq_state <= IRQ_PEND;
                    end
                end
                IRQ_PEND: begin
                    if (!irq_req) begin
                        r_irq_state <= IRQ_IDLE;
                    end else if (w_clean || w_due) begin
                        r_irq_state <= IRQ_TAKE;
                    end else if (r_timer < TMR_DUE) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                IRQ_TAKE: begin
                    r_irq_state <= IRQ_MASKED;
                end
                IRQ_MASKED: begin
                    if (id_eret) begin
                        r_irq_state <= IRQ_IDLE;
                    end
                end
                default: begin
                    r_irq_state <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign irq_state = r_irq_state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .inc    (w_stall_inc),
        .count  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .inc    (if_flush),
        .count  (flush_cnt)
    );

endmodule
